// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receiver.
package shift_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/shift_deser8_hold.sv
// Output holding register: takes each completed word if there is room,
// otherwise drops it and pulses overrun for one cycle.
module shift_deser8_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    // A full register can still take a word on the same edge that drains it.
    logic has_room;
    assign has_room = !data_valid || data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (has_room) begin
                    data_out   <= word;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_deser8.sv
// Serial-to-parallel receiver: collects WIDTH enabled bits framed by sync,
// in either bit order, and hands the word to a valid/ready holding register.
module shift_deser8
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             serial_in,
    input  logic             shift_direction,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dir_q, dir_next;
    logic [WIDTH-1:0] sr, sr_next;
    logic             word_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir_q <= DIR_LSB_FIRST;
            sr    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dir_q <= dir_next;
            sr    <= sr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir_q;
        sr_next    = sr;
        word_done  = 1'b0;
        if (enable) begin
            if (sync) begin
                // The first bit is placed where WIDTH-1 further shifts carry it
                // to its final position; stale bits of an abandoned frame clear.
                dir_next   = shift_direction;
                sr_next    = (shift_direction == DIR_MSB_FIRST)
                             ? {{(WIDTH-1){1'b0}}, serial_in}
                             : {serial_in, {(WIDTH-1){1'b0}}};
                cnt_next   = CNT_W'(1);
                state_next = ST_RECV;
            end else if (state == ST_RECV) begin
                sr_next = (dir_q == DIR_MSB_FIRST)
                          ? {sr[WIDTH-2:0], serial_in}
                          : {serial_in, sr[WIDTH-1:1]};
                if (cnt == CNT_W'(WIDTH-1)) begin
                    word_done  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state == ST_RECV);

    // The assembled word including the final bit goes straight to the holder.
    shift_deser8_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .word       (sr_next),
        .word_done  (word_done),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_shift_deser8.sv
// Directed bench for shift_deser8: a frame-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_shift_deser8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         sync = 1'b0;
    logic         serial_in = 1'b0;
    logic         shift_direction = 1'b0;
    logic         data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;

    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    int busy_cycles = 0;
    int ovr_pulses  = 0;

    shift_deser8 #(.WIDTH(W), .CNT_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .sync            (sync),
        .serial_in       (serial_in),
        .shift_direction (shift_direction),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .busy            (busy),
        .overrun         (overrun)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // ---------------- frame-level model ----------------
    logic         m_bits[$];
    logic         m_dir = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_ovr = 1'b0;

    function automatic logic [W-1:0] assemble(input logic dir);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (dir) w[W-1-i] = m_bits[i];
            else     w[i]     = m_bits[i];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        logic         done;
        logic [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (reset) begin
            m_bits.delete();
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_ovr   = 1'b0;
        end else begin
            m_ovr = 1'b0;
            if (enable) begin
                if (sync) begin
                    m_bits.delete();
                    m_bits.push_back(serial_in);
                    m_dir  = shift_direction;
                    m_busy = 1'b1;
                end else if (m_busy) begin
                    m_bits.push_back(serial_in);
                    if (m_bits.size() == W) begin
                        done   = 1'b1;
                        word   = assemble(m_dir);
                        m_busy = 1'b0;
                        m_bits.delete();
                    end
                end
            end
            if (done) begin
                if (!m_valid || data_ready) begin
                    m_data  = word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("cyc_data_out", 32'(data_out), 32'(m_data));
            check("cyc_data_valid", 32'(data_valid), 32'(m_valid));
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_overrun", 32'(overrun), 32'(m_ovr));
            if (busy) busy_cycles++;
            if (overrun) ovr_pulses++;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_bit(input logic en, input logic sy, input logic b, input logic dir, input logic rdy);
        @(negedge clk);
        enable          = en;
        sync            = sy;
        serial_in       = b;
        shift_direction = dir;
        data_ready      = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, rdy);
    endtask

    // Sends nbits of word w in the given order; gap inserts a disabled cycle
    // after every bit; rdy_last is data_ready on the final bit's cycle.
    task automatic send_frame(input logic [W-1:0] w, input logic dir, input bit gap,
                              input logic rdy, input logic rdy_last, input int nbits);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = dir ? w[W-1-i] : w[i];
            send_bit(1'b1, (i == 0), b, dir, (i == W-1) ? rdy_last : rdy);
            if (gap && i != nbits-1) send_bit(1'b0, 1'b0, ~b, ~dir, rdy);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        @(posedge clk);
        started = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // 1: LSB first, bits 1,0,1,0,0,1,0,1
        busy_cycles = 0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t1_data", 32'(data_out), 32'hA5);
        check("t1_valid", 32'(data_valid), 32'h1);
        idle(1, 1'b1);
        check("t1_valid_drained", 32'(data_valid), 32'h0);
        check("t1_data_held", 32'(data_out), 32'hA5);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd7);

        // 2: MSB first, and bit-order checks on 0..01
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t2_msb_a5", 32'(data_out), 32'hA5);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t2_msb_01", 32'(data_out), 32'h01);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t2_lsb_80", 32'(data_out), 32'h80);

        // 3: gapped enable
        busy_cycles = 0;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t3_gapped", 32'(data_out), 32'h3C);
        check("t3_busy_cycles", 32'(busy_cycles), 32'd14);

        // 4: overrun with data_ready held low
        idle(2, 1'b1);
        ovr_pulses = 0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, W);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, W);
        idle(1, 1'b0);
        check("t4_data_kept", 32'(data_out), 32'h11);
        check("t4_valid", 32'(data_valid), 32'h1);
        idle(2, 1'b0);
        check("t4_ovr_pulses", 32'(ovr_pulses), 32'd1);

        // 5: drain and fill on the same edge
        ovr_pulses = 0;
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, W);
        idle(1, 1'b0);
        check("t5_data", 32'(data_out), 32'h22);
        check("t5_valid", 32'(data_valid), 32'h1);
        check("t5_no_ovr", 32'(ovr_pulses), 32'd0);
        idle(1, 1'b1);

        // 6a: resync after 4 bits
        ovr_pulses = 0;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t6_resync_data", 32'(data_out), 32'h5A);
        check("t6_resync_no_ovr", 32'(ovr_pulses), 32'd0);
        idle(1, 1'b0);

        // 6b: reset mid-frame, then a clean frame
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_valid", 32'(data_valid), 32'h0);
        check("t6_rst_data", 32'(data_out), 32'h00);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, W);
        idle(1, 1'b1);
        check("t6_after_rst", 32'(data_out), 32'hC3);
        idle(2, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
